// File: rtl/dvi_line_fetch_scheduler.sv
// Ping-pong line-buffer fetch scheduler for DVI scanout: splits each line into
// fixed-length read bursts and steers the returned words into the fill buffer.
module dvi_line_fetch_scheduler #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int BURST_LEN   = 32,
    parameter int LINE_STRIDE = 800,
    parameter int FB_BASE     = 0,
    parameter int ADDR_W      = 24
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              line_done,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    input  logic              rd_valid,
    output logic              wr_en,
    output logic              wr_buf,
    output logic [9:0]        wr_addr,
    output logic              disp_buf,
    output logic              line_ready,
    output logic              underflow,
    output logic              busy
);
    localparam int NUM_BURSTS = H_ACTIVE / BURST_LEN;
    localparam int BC_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int WC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int FL_W = $clog2(V_ACTIVE + 1);

    localparam logic [BC_W-1:0]   LAST_BURST = BC_W'(NUM_BURSTS - 1);
    localparam logic [BC_W-1:0]   BC_ONE     = BC_W'(1);
    localparam logic [WC_W-1:0]   LAST_WORD  = WC_W'(BURST_LEN - 1);
    localparam logic [WC_W-1:0]   WC_ONE     = WC_W'(1);
    localparam logic [FL_W-1:0]   NUM_LINES  = FL_W'(V_ACTIVE);
    localparam logic [FL_W-1:0]   FL_ONE     = FL_W'(1);
    localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(FB_BASE);
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(LINE_STRIDE);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_r, state_n;
    logic [1:0]        full_r, full_n;
    logic              fill_buf_r, fill_buf_n;
    logic              disp_buf_n;
    logic [FL_W-1:0]   fetch_line_r, fetch_line_n;
    logic [BC_W-1:0]   burst_cnt_r, burst_cnt_n;
    logic [WC_W-1:0]   word_cnt_r, word_cnt_n;
    logic [ADDR_W-1:0] line_addr_r, line_addr_n;
    logic [ADDR_W-1:0] cmd_addr_n;
    logic              underflow_n;
    logic              word_last_s;

    assign cmd_len = 8'(BURST_LEN);
    assign wr_en   = (state_r == WAIT) && rd_valid;
    assign wr_buf  = fill_buf_r;
    assign wr_addr = 10'(burst_cnt_r) * 10'(BURST_LEN) + 10'(word_cnt_r);

    // Next-state, counters and buffer bookkeeping
    always_comb begin
        state_n      = state_r;
        full_n       = full_r;
        fill_buf_n   = fill_buf_r;
        disp_buf_n   = disp_buf;
        fetch_line_n = fetch_line_r;
        burst_cnt_n  = burst_cnt_r;
        word_cnt_n   = word_cnt_r;
        line_addr_n  = line_addr_r;
        underflow_n  = underflow;
        word_last_s  = (word_cnt_r == LAST_WORD);

        case (state_r)
            IDLE: begin
                if (enable && (fetch_line_r < NUM_LINES) && !full_r[fill_buf_r] && !frame_start) begin
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                // An accepted burst must still be absorbed even if the frame restarts
                if (cmd_ready) begin
                    state_n = frame_start ? DRAIN : WAIT;
                end else if (frame_start) begin
                    state_n = IDLE;
                end else begin
                    state_n = ISSUE;
                end
            end
            WAIT: begin
                if (rd_valid && word_last_s) begin
                    word_cnt_n = {WC_W{1'b0}};
                    if (burst_cnt_r == LAST_BURST) begin
                        full_n[fill_buf_r] = 1'b1;
                        fill_buf_n         = ~fill_buf_r;
                        fetch_line_n       = fetch_line_r + FL_ONE;
                        line_addr_n        = line_addr_r + STRIDE;
                        burst_cnt_n        = {BC_W{1'b0}};
                        state_n            = IDLE;
                    end else begin
                        burst_cnt_n = burst_cnt_r + BC_ONE;
                        state_n     = frame_start ? IDLE : ISSUE;
                    end
                end else if (rd_valid) begin
                    word_cnt_n = word_cnt_r + WC_ONE;
                    state_n    = frame_start ? DRAIN : WAIT;
                end else begin
                    state_n = frame_start ? DRAIN : WAIT;
                end
            end
            DRAIN: begin
                if (rd_valid && word_last_s) begin
                    word_cnt_n = {WC_W{1'b0}};
                    state_n    = IDLE;
                end else if (rd_valid) begin
                    word_cnt_n = word_cnt_r + WC_ONE;
                    state_n    = DRAIN;
                end else begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // line_done tests the registered flag, so a same-cycle fill still underflows
        if (frame_start) begin
            full_n       = 2'b00;
            fill_buf_n   = 1'b0;
            disp_buf_n   = 1'b0;
            fetch_line_n = {FL_W{1'b0}};
            burst_cnt_n  = {BC_W{1'b0}};
            line_addr_n  = BASE_ADDR;
            underflow_n  = 1'b0;
        end else if (line_done && full_r[disp_buf]) begin
            full_n[disp_buf] = 1'b0;
            disp_buf_n       = ~disp_buf;
        end else if (line_done) begin
            underflow_n = 1'b1;
        end else begin
            disp_buf_n = disp_buf;
        end

        cmd_addr_n = line_addr_n + ADDR_W'(burst_cnt_n) * BURST_STEP;
    end

    // State register and registered outputs
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            full_r       <= 2'b00;
            fill_buf_r   <= 1'b0;
            fetch_line_r <= {FL_W{1'b0}};
            burst_cnt_r  <= {BC_W{1'b0}};
            word_cnt_r   <= {WC_W{1'b0}};
            line_addr_r  <= BASE_ADDR;
            cmd_valid    <= 1'b0;
            cmd_addr     <= BASE_ADDR;
            disp_buf     <= 1'b0;
            line_ready   <= 1'b0;
            underflow    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_n;
            full_r       <= full_n;
            fill_buf_r   <= fill_buf_n;
            fetch_line_r <= fetch_line_n;
            burst_cnt_r  <= burst_cnt_n;
            word_cnt_r   <= word_cnt_n;
            line_addr_r  <= line_addr_n;
            cmd_valid    <= (state_n == ISSUE);
            cmd_addr     <= cmd_addr_n;
            disp_buf     <= disp_buf_n;
            line_ready   <= full_n[disp_buf_n];
            underflow    <= underflow_n;
            busy         <= (state_n != IDLE);
        end
    end

endmodule
